block_launcher: RTL
===================

# block_launcher

Core-side receiver of the dispatcher's per-core block protocol (start / reset / block_id / done). Sits at the top of each core: latches the assigned block ID, launches the block's warps into free warp slots over a valid/ready handshake, counts warp retirements, and raises done to the dispatcher once every warp of the block has retired. Holds done until the dispatcher's block reset.

## Interface
Parameters:
- NUM_WARP_SLOTS, 4, hardware warp contexts per core (1..16)
- PC_WIDTH, 8, instruction address width

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- kernel_config  in  kernel_config_t  kernel metadata; uses num_warps_per_block and base_instructions_address
- start  in  1  dispatcher core_start for this core; level
- block_reset  in  1  dispatcher core_reset for this core; synchronous, active-high soft clear
- block_id  in  8  block index; valid while start is high
- done  out  1  block complete; dispatcher core_done
- launch_valid  out  1  warp launch request
- launch_ready  in  1  warp slot accepts launch
- launch_slot  out  $clog2(NUM_WARP_SLOTS) (min 1)  target slot
- launch_warp_id  out  8  warp index within block
- launch_block_id  out  8  latched block ID
- launch_pc  out  PC_WIDTH  start PC = base_instructions_address
- warp_done  in  NUM_WARP_SLOTS  one-cycle retire pulse per slot
- warp_abort  out  1  one-cycle kill of all busy slots

## Operation
- States: IDLE, LAUNCH, RUN, DONE (launcher_state_t).
- Reset (reset_n low): state IDLE; done, launch_valid, warp_abort 0; launch_slot, launch_warp_id, launch_block_id, launch_pc 0; counters 0; slot_busy all 0.
- IDLE: start=1 and block_reset=0 -> latch block_id, clear launched/retired counters -> LAUNCH. If num_warps_per_block==0 -> DONE directly.
- LAUNCH: launch_valid=1 whenever any slot is free; launch_slot = lowest-index free slot per registered slot_busy. Payload stable while valid and not ready. On valid&ready: set slot_busy[slot], increment launched. After last warp (launched == num_warps_per_block) accepted -> RUN.
- Oversubscription: num_warps_per_block > NUM_WARP_SLOTS is legal; launcher stalls (valid=0) until a slot retires.
- Retire: warp_done[i] with slot_busy[i] clears the bit and increments retired; warp_done on a non-busy slot is ignored. Multiple retire pulses in one cycle count via popcount.
- RUN: retired == num_warps_per_block -> DONE.
- DONE: done=1, held until block_reset. start remaining high does not relaunch.
- block_reset in any state: next cycle state IDLE, done 0, launch_valid 0, slot_busy cleared, counters cleared; warp_abort pulses one cycle if any slot was busy. block_reset overrides start in the same cycle.
- Counters 8 bits; num_warps_per_block up to 255.

## Timing
- launch_valid first high the cycle after start is sampled in IDLE.
- Max one launch per cycle; back-to-back launches with ready held high.
- Slot freed by warp_done at cycle N is selectable from cycle N+1; no same-cycle reuse.
- done rises the cycle after the final retire is counted (or the cycle after start for zero warps).
- Retire of slot i and launch into slot j in the same cycle both take effect.

## Configuration
- BLOCK_LAUNCHER_PERF_EN defined: adds output block_cycles (16 bits), counting cycles from IDLE->LAUNCH through entry to DONE, saturating at 0xFFFF, frozen in DONE, cleared on block_reset/reset_n.
- Undefined: no port, no counter logic.

## Structure
- Shared package (common.sv): launcher_state_t, warp_launch_t (slot, warp_id, block_id, pc), kernel_config_t field use unchanged.
- Sub-module: free_slot_picker (lowest-set-bit priority encoder over ~slot_busy, with any_free flag).

## Test plan
- 2 warps/block, 4 slots, ready=1, block_id=5 -> launches warp 0 slot 0, warp 1 slot 1, block_id 5; retire both -> done 1 cycle later, held until block_reset.
- 6 warps/block, 4 slots -> 4 launches, valid low; retire slot 2 -> next launch warp 4 into slot 2; done only after 6 retires.
- ready held low 3 cycles -> valid and payload stable; accepted on 4th cycle.
- num_warps_per_block=0, start=1 -> no launch, done 1 cycle after start.
- block_reset mid-RUN with 3 busy slots -> warp_abort one pulse, done 0, next start relaunches from warp 0.
- reset_n low mid-LAUNCH -> all outputs 0 immediately; with PERF_EN, 3-warp block with fixed 10-cycle warps yields deterministic block_cycles.

Source files
------------

// File: rtl/block_launcher_pkg.sv
// rtl/block_launcher_pkg.sv - shared types and helpers for the core-side block launcher
//
// Purpose: types shared by block_launcher and its bench.
//   launcher_state_t : FSM state encoding (IDLE, LAUNCH, RUN, DONE)
//   kernel_config_t  : kernel metadata; the launcher uses num_warps_per_block
//                      and base_instructions_address
//   warp_launch_t    : one warp launch offer (slot, warp_id, block_id, pc)
//   popcount16       : number of set bits in a 16-bit vector
// No ports (package).
package block_launcher_pkg;

  // Widest slot index (16 warp slots) and widest start PC carried in the structs.
  localparam int MAX_SLOT_W = 4;
  localparam int MAX_PC_W   = 16;

  typedef logic [1:0] launcher_state_t;
  localparam launcher_state_t ST_IDLE   = 2'd0;
  localparam launcher_state_t ST_LAUNCH = 2'd1;
  localparam launcher_state_t ST_RUN    = 2'd2;
  localparam launcher_state_t ST_DONE   = 2'd3;

  typedef struct packed {
    logic [7:0]          num_warps_per_block;
    logic [MAX_PC_W-1:0] base_instructions_address;
  } kernel_config_t;

  typedef struct packed {
    logic [MAX_SLOT_W-1:0] slot;
    logic [7:0]            warp_id;
    logic [7:0]            block_id;
    logic [MAX_PC_W-1:0]   pc;
  } warp_launch_t;

  function automatic logic [7:0] popcount16(input logic [15:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/free_slot_picker.sv
// rtl/free_slot_picker.sv - lowest-index free warp slot priority encoder
//
// Purpose: picks the lowest-numbered slot whose busy bit is clear.
// Ports:
//   slot_busy  in   NUM_SLOTS  busy flag per warp slot
//   free_slot  out  SLOT_W     index of the lowest free slot (0 when none free)
//   any_free   out  1          at least one slot is free
module free_slot_picker #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input  logic [NUM_SLOTS-1:0] slot_busy,
  output logic [SLOT_W-1:0]    free_slot,
  output logic                 any_free
);

  // Scan from the top down so the last (lowest) free index wins.
  always_comb begin
    free_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        free_slot = SLOT_W'(i);
      end
    end
  end

  assign any_free = ~&slot_busy;

endmodule

// File: rtl/block_launcher.sv
// rtl/block_launcher.sv - core-side block receiver: launches a block's warps and reports done
//
// Purpose: latches the dispatcher's block ID on start, offers each warp of the
// block to a free warp slot over a valid/ready handshake, counts retirements
// and raises done once every warp has retired. done is held until block_reset.
// Optional feature macro: BLOCK_LAUNCHER_PERF_EN adds the block_cycles output.
// Ports:
//   clk              in   1          core clock
//   reset_n          in   1          asynchronous active-low reset
//   kernel_config    in   struct     num_warps_per_block, base_instructions_address
//   start            in   1          dispatcher start (level)
//   block_reset      in   1          synchronous active-high soft clear
//   block_id         in   8          block index, valid while start is high
//   done             out  1          block complete
//   launch_valid     out  1          warp launch request
//   launch_ready     in   1          warp slot accepts the launch
//   launch_slot      out  SLOT_W     target slot
//   launch_warp_id   out  8          warp index within the block
//   launch_block_id  out  8          latched block ID
//   launch_pc        out  PC_WIDTH   start PC
//   warp_done        in   NUM_WARP_SLOTS  one-cycle retire pulse per slot
//   warp_abort       out  1          one-cycle kill of all busy slots
//   block_cycles     out  16         (BLOCK_LAUNCHER_PERF_EN only) cycles spent launching/running
module block_launcher
  import block_launcher_pkg::*;
#(
  parameter int NUM_WARP_SLOTS = 4,
  parameter int PC_WIDTH       = 8,
  localparam int SLOT_W        = (NUM_WARP_SLOTS > 1) ? $clog2(NUM_WARP_SLOTS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  kernel_config_t            kernel_config,
  input  logic                      start,
  input  logic                      block_reset,
  input  logic [7:0]                block_id,
  output logic                      done,
  output logic                      launch_valid,
  input  logic                      launch_ready,
  output logic [SLOT_W-1:0]         launch_slot,
  output logic [7:0]                launch_warp_id,
  output logic [7:0]                launch_block_id,
  output logic [PC_WIDTH-1:0]       launch_pc,
  input  logic [NUM_WARP_SLOTS-1:0] warp_done,
  output logic                      warp_abort
`ifdef BLOCK_LAUNCHER_PERF_EN
  ,
  output logic [15:0]               block_cycles
`endif
);

  launcher_state_t           state_q, state_d;
  logic                      done_q, done_d;
  logic                      valid_q, valid_d;
  logic                      abort_q, abort_d;
  warp_launch_t              offer_q, offer_d;
  logic [7:0]                launched_q, launched_d;
  logic [7:0]                retired_q, retired_d;
  logic [NUM_WARP_SLOTS-1:0] slot_busy_q, slot_busy_d;

  logic                      accept;
  logic [NUM_WARP_SLOTS-1:0] retire_mask;
  logic [NUM_WARP_SLOTS-1:0] launch_mask;
  logic [NUM_WARP_SLOTS-1:0] busy_upd;
  logic [7:0]                launched_upd;
  logic [7:0]                retired_upd;
  logic [7:0]                num_warps;
  logic [SLOT_W-1:0]         pick_slot;
  logic                      pick_any;

  assign num_warps = kernel_config.num_warps_per_block;
  assign accept    = valid_q & launch_ready;

  // Retire pulses on idle slots are dropped here.
  assign retire_mask = warp_done & slot_busy_q;
  assign launch_mask = accept ? (NUM_WARP_SLOTS'(1) << offer_q.slot[SLOT_W-1:0]) : '0;

  // Occupancy after this cycle's retires and launch. The next offer is picked
  // from this, so a slot freed now is offered next cycle, never this one.
  assign busy_upd     = (slot_busy_q & ~retire_mask) | launch_mask;
  assign launched_upd = launched_q + {7'd0, accept};
  assign retired_upd  = retired_q + popcount16(16'(retire_mask));

  free_slot_picker #(
    .NUM_SLOTS (NUM_WARP_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_picker (
    .slot_busy (busy_upd),
    .free_slot (pick_slot),
    .any_free  (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    valid_d     = valid_q;
    abort_d     = 1'b0;
    offer_d     = offer_q;
    launched_d  = launched_upd;
    retired_d   = retired_upd;
    slot_busy_d = busy_upd;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          launched_d       = '0;
          retired_d        = '0;
          offer_d.block_id = block_id;
          offer_d.warp_id  = '0;
          offer_d.slot     = MAX_SLOT_W'(pick_slot);
          offer_d.pc       = kernel_config.base_instructions_address;
          if (num_warps == 8'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_LAUNCH;
            valid_d = pick_any;
          end
        end
      end

      ST_LAUNCH: begin
        // A stalled offer keeps its payload; otherwise build the next one.
        if (!(valid_q && !launch_ready)) begin
          if (launched_upd == num_warps) begin
            state_d = ST_RUN;
            valid_d = 1'b0;
          end else begin
            valid_d         = pick_any;
            offer_d.slot    = MAX_SLOT_W'(pick_slot);
            offer_d.warp_id = launched_upd;
            offer_d.pc      = kernel_config.base_instructions_address;
          end
        end
      end

      ST_RUN: begin
        if (retired_upd == num_warps) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      ST_DONE: begin
        done_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Soft clear wins over everything, including a start in the same cycle.
    if (block_reset) begin
      state_d     = ST_IDLE;
      done_d      = 1'b0;
      valid_d     = 1'b0;
      offer_d     = '0;
      launched_d  = '0;
      retired_d   = '0;
      slot_busy_d = '0;
      abort_d     = |slot_busy_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      abort_q     <= 1'b0;
      offer_q     <= '0;
      launched_q  <= '0;
      retired_q   <= '0;
      slot_busy_q <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      abort_q     <= abort_d;
      offer_q     <= offer_d;
      launched_q  <= launched_d;
      retired_q   <= retired_d;
      slot_busy_q <= slot_busy_d;
    end
  end

  assign done            = done_q;
  assign launch_valid    = valid_q;
  assign launch_slot     = offer_q.slot[SLOT_W-1:0];
  assign launch_warp_id  = offer_q.warp_id;
  assign launch_block_id = offer_q.block_id;
  assign launch_pc       = offer_q.pc[PC_WIDTH-1:0];
  assign warp_abort      = abort_q;

  // The offer struct is sized for the widest configuration; the upper bits
  // are simply not driven out in narrower builds.
  logic unused_offer_bits;
  assign unused_offer_bits = ^{offer_q.slot, offer_q.pc};

`ifdef BLOCK_LAUNCHER_PERF_EN
  logic [15:0] block_cycles_q, block_cycles_d;

  // Counts every cycle spent in LAUNCH or RUN, so the value frozen in DONE is
  // the block's launch-to-completion latency.
  always_comb begin
    block_cycles_d = block_cycles_q;
    if (block_reset) begin
      block_cycles_d = '0;
    end else if (state_q == ST_IDLE && start) begin
      block_cycles_d = '0;
    end else if ((state_q == ST_LAUNCH || state_q == ST_RUN) && block_cycles_q != 16'hFFFF) begin
      block_cycles_d = block_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      block_cycles_q <= '0;
    end else begin
      block_cycles_q <= block_cycles_d;
    end
  end

  assign block_cycles = block_cycles_q;
`endif

endmodule
